// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the FIFO control blocks.
package fifo_ctrl_pkg;

    // Default beat width for ready/valid datapaths.
    localparam int data_width = 8;

endpackage : fifo_ctrl_pkg

// File: rtl/vr_fifo_if.sv
// Decoupled ready/valid channel: the producer drives valid/data and the consumer drives ready.
interface vr_fifo_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    // The producer of beats.
    modport master (output valid, output data, input ready);

    // The consumer of beats.
    modport slave (input valid, input data, output ready);

endinterface : vr_fifo_if

// File: rtl/vr_fifo.sv
// First-word-fall-through FIFO between two ready/valid channels.
// Both handshake outputs depend only on registered pointers and flush, so there is
// no combinational path from out_ready to in_ready or from in_valid to out_valid.
module vr_fifo
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = data_width,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    vr_fifo_if.slave                   in_if,
    vr_fifo_if.master                  out_if,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A full FIFO never takes a beat, even when the head is popping this cycle.
    assign in_if.ready  = !full && !flush;
    assign out_if.valid = !empty && !flush;
    assign out_if.data  = mem[rd_ptr[AW-1:0]];

    assign push = in_if.valid && in_if.ready;
    assign pop  = out_if.valid && out_if.ready;

    // Occupancy is the pointer distance; modulo 2*DEPTH arithmetic makes wrap transparent.
    assign count       = CW'(wr_ptr - rd_ptr);
    assign almost_full = (count >= CW'(AFULL_THRESH));

    // Write pointer: advances on every accepted beat.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Read pointer: advances on pop; a flush snaps it onto the write pointer to empty the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array: written at the write pointer on each accepted beat.
    // NOTE: the array has no reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_if.data;
        end
    end

endmodule : vr_fifo

// File: tb/tb_vr_fifo.sv
// Self-checking bench for vr_fifo: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_vr_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [2:0]    count;
    logic          almost_full;

    vr_fifo_if #(.DATA_WIDTH(DW)) in_bus ();
    vr_fifo_if #(.DATA_WIDTH(DW)) out_bus ();

    vr_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_if       (in_bus),
        .out_if      (out_bus),
        .flush       (flush),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents in order, head at index 0.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] popped[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, compare outputs against the
    // model, advance the model by the handshakes the rules allow, then wait for the next fall.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        logic exp_ir;
        logic exp_ov;
        in_bus.valid  = iv;
        in_bus.data   = d;
        out_bus.ready = ordy;
        flush         = fl;
        #1;
        exp_ir = (model_q.size() < DEPTH) && !fl;
        exp_ov = (model_q.size() != 0) && !fl;
        check("in_ready", {31'b0, in_bus.ready}, {31'b0, exp_ir});
        check("out_valid", {31'b0, out_bus.valid}, {31'b0, exp_ov});
        check("count", {29'b0, count}, model_q.size());
        check("almost_full", {31'b0, almost_full}, {31'b0, model_q.size() >= AFULL});
        if (exp_ov) check("out_data", {24'b0, out_bus.data}, {24'b0, model_q[0]});
        if (fl) begin
            model_q.delete();
        end else begin
            if (exp_ov && ordy) popped.push_back(model_q.pop_front());
            if (exp_ir && iv) model_q.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        in_bus.valid  = 1'b0;
        in_bus.data   = '0;
        out_bus.ready = 1'b0;

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_in_ready", {31'b0, in_bus.ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_bus.valid}, 32'd0);
        check("rst_afull", {31'b0, almost_full}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: three pushes with the consumer stalled; head stays 0xA1.
        step(1, 8'hA1, 0, 0);
        step(1, 8'hA2, 0, 0);
        step(1, 8'hA3, 0, 0);
        step(0, 8'h00, 0, 0);
        check("t1_count", {29'b0, count}, 32'd3);
        check("t1_afull", {31'b0, almost_full}, 32'd1);
        check("t1_head", {24'b0, out_bus.data}, 32'hA1);

        // 2: fill, then a full FIFO pops but refuses 0xA5 in the same cycle.
        step(1, 8'hA4, 0, 0);
        step(1, 8'hA5, 1, 0);
        check("t2_pop", {24'b0, popped[popped.size()-1]}, 32'hA1);
        check("t2_count_after_pop", {29'b0, count}, 32'd3);
        step(1, 8'hA5, 0, 0);
        check("t2_count_after_push", {29'b0, count}, 32'd4);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        check("t2_last", {24'b0, popped[popped.size()-1]}, 32'hA5);

        // 3: no same-cycle fall-through into an empty FIFO.
        step(1, 8'h55, 1, 0);
        check("t3_head", {24'b0, out_bus.data}, 32'h55);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        check("t3_empty", {29'b0, count}, 32'd0);

        // 4: streaming at half full across several pointer wraps.
        popped.delete();
        step(1, 8'd0, 0, 0);
        step(1, 8'd1, 0, 0);
        for (int i = 2; i < 20; i++) begin
            step(1, DW'(i), 1, 0);
            check("t4_count", {29'b0, count}, 32'd2);
        end
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        check("t4_popped", popped.size(), 32'd20);
        for (int i = 0; i < 20; i++) check("t4_order", {24'b0, popped[i]}, i);

        // 5: flush with a beat waiting; it is taken right after the flush.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h77, 1, 1);
        check("t5_count_flushed", {29'b0, count}, 32'd0);
        step(1, 8'h77, 0, 0);
        step(0, 8'h00, 0, 0);
        check("t5_accepted", {24'b0, out_bus.data}, 32'h77);
        step(0, 8'h00, 1, 0);

        // 6: random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 63) == 0));
        end

        // Mid-operation reset loses contents; beats offered during reset are not taken.
        step(1, 8'hC1, 0, 0);
        step(1, 8'hC2, 0, 0);
        rst_n        = 1'b0;
        in_bus.valid = 1'b1;
        in_bus.data  = 8'hC3;
        #1;
        check("mid_rst_count", {29'b0, count}, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_bus.valid}, 32'd0);
        model_q.delete();
        @(negedge clk);
        check("mid_rst_hold", {29'b0, count}, 32'd0);
        rst_n = 1'b1;
        step(1, 8'hC3, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vr_fifo
